// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM state and grant encodings, bus field widths,
// and the packed bundle of latched bus request fields.
// No ports; import with "import mem_arbiter_pkg::*;".
package mem_arbiter_pkg;

  localparam int RegBus      = 32;
  localparam int ArbStateBus = 2;

  typedef enum logic [ArbStateBus-1:0] {
    ArbIdle    = 2'd0,
    ArbIfBusy  = 2'd1,
    ArbMemBusy = 2'd2
  } arb_state_e;

  typedef enum logic {
    GrantIf  = 1'b0,
    GrantMem = 1'b1
  } grant_e;

  // Fields presented on the memory bus for the transaction in flight.
  typedef struct packed {
    logic              we;
    logic [3:0]        sel;
    logic [RegBus-1:0] addr;
    logic [RegBus-1:0] wdata;
  } bus_fields_t;

  localparam logic [3:0] SelAll = 4'b1111;

endpackage

// File: rtl/mem_arbiter_arb_timer.sv
// Busy-cycle counter for mem_arbiter; raises timeout_o in the busy cycle whose
// count equals TIMEOUT_CYCLES-1. Latency: timeout_o is combinational from the count.
// Backpressure: none; clear_i restarts the count on every new grant.
// Ports: clk, rst (sync, active-high), clear_i (grant), busy_i (FSM busy), timeout_o.
module arb_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic busy_i,
  output logic timeout_o
);

  localparam int              CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count holds at its last value; the FSM leaves BUSY in that same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (busy_i && (cnt_q != CntLast)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = busy_i && (cnt_q == CntLast);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between the fetch port (if_*) and the data
// port (mem_*). Latency: grant registered in IDLE, bus_req_o the next cycle, ack
// combinational with bus_ack_i. Backpressure: a waiting requester holds its
// request and sees stallreq_o until acked; the slave stretches via bus_ack_i.
// Ports: clk/rst, if_* fetch requester, mem_* data requester, bus_* memory side,
// stallreq_o to pipeline control.
// Optional: define MEM_ARB_TIMEOUT_EN to abort transfers after TIMEOUT_CYCLES
// busy cycles without bus_ack_i (owner gets ack with err set, data 0).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [RegBus-1:0] if_addr_i,
  output logic [RegBus-1:0] if_data_o,
  output logic              if_ack_o,
  output logic              if_err_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [RegBus-1:0] mem_addr_i,
  input  logic [RegBus-1:0] mem_wdata_i,
  output logic [RegBus-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              mem_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [RegBus-1:0] bus_addr_o,
  output logic [RegBus-1:0] bus_wdata_o,
  input  logic [RegBus-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              stallreq_o
);

  arb_state_e  state_q, state_d;
  grant_e      last_grant_q, last_grant_d;
  bus_fields_t bus_q, bus_d;

  logic grant_if, grant_mem;
  logic busy;
  logic timeout;
  logic done;

  assign busy = (state_q != ArbIdle);

  // Under contention the requester that did not win last time gets the bus.
  assign grant_mem = (state_q == ArbIdle) && mem_req_i &&
                     (!if_req_i || (last_grant_q == GrantIf));
  assign grant_if  = (state_q == ArbIdle) && if_req_i && !grant_mem;

`ifdef MEM_ARB_TIMEOUT_EN
  arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_arb_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (grant_if || grant_mem),
    .busy_i   (busy),
    .timeout_o(timeout)
  );
`else
  // The budget only sizes the timer; without it the arbiter waits on the slave.
  if (TIMEOUT_CYCLES < 1) begin : g_no_budget
  end
  assign timeout = 1'b0;
`endif

  // A transfer interrupted by reset completes silently.
  assign done = busy && !rst && (bus_ack_i || timeout);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ArbIdle;
      last_grant_q <= GrantIf;
      bus_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bus_q        <= bus_d;
    end
  end

  // Next-state logic; bus fields are captured only at grant and held while busy.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bus_d        = bus_q;
    case (state_q)
      ArbIdle: begin
        if (grant_mem) begin
          state_d = ArbMemBusy;
          bus_d   = '{we: mem_we_i, sel: mem_sel_i, addr: mem_addr_i, wdata: mem_wdata_i};
        end else if (grant_if) begin
          state_d = ArbIfBusy;
          bus_d   = '{we: 1'b0, sel: SelAll, addr: if_addr_i, wdata: '0};
        end
      end
      ArbIfBusy: begin
        if (done) begin
          state_d      = ArbIdle;
          last_grant_d = GrantIf;
        end
      end
      ArbMemBusy: begin
        if (done) begin
          state_d      = ArbIdle;
          last_grant_d = GrantMem;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Outputs. done without bus_ack_i can only be a timeout abort.
  always_comb begin
    if_ack_o    = 1'b0;
    if_err_o    = 1'b0;
    if_data_o   = '0;
    mem_ack_o   = 1'b0;
    mem_err_o   = 1'b0;
    mem_rdata_o = '0;
    case (state_q)
      ArbIfBusy: begin
        if_ack_o  = done;
        if_err_o  = done && !bus_ack_i;
        if_data_o = (done && bus_ack_i) ? bus_rdata_i : '0;
      end
      ArbMemBusy: begin
        mem_ack_o   = done;
        mem_err_o   = done && !bus_ack_i;
        mem_rdata_o = (done && bus_ack_i) ? bus_rdata_i : '0;
      end
      default: ;
    endcase
  end

  assign bus_req_o   = busy;
  assign bus_we_o    = bus_q.we;
  assign bus_sel_o   = bus_q.sel;
  assign bus_addr_o  = bus_q.addr;
  assign bus_wdata_o = bus_q.wdata;

  assign stallreq_o = (if_req_i && !if_ack_o) || (mem_req_i && !mem_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized requesters and
// a randomized slave, every cycle compared against a transaction-level model.
// Timeout scenarios run only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  localparam int TO      = 4;
  localparam int NONE    = 0;
  localparam int OWN_IF  = 1;
  localparam int OWN_MEM = 2;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, mem_req, mem_we, bus_ack;
  logic [3:0]  mem_sel;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [31:0] if_data_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_ack_o, if_err_o, mem_ack_o, mem_err_o, bus_req_o, bus_we_o, stallreq_o;
  logic [3:0]  bus_sel_o;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data_o),
    .if_ack_o(if_ack_o), .if_err_o(if_err_o),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata_o),
    .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack), .stallreq_o(stallreq_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the bus, who won last, busy cycles elapsed, and
  // the fields captured from the winner.
  int          m_owner = NONE, m_last = OWN_IF, m_cnt = 0;
  logic        m_we = 1'b0;
  logic [3:0]  m_sel = 4'h0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
  logic        e_if_ack = 1'b0, e_mem_ack = 1'b0;
  logic        s_if_ack = 1'b0, s_mem_ack = 1'b0;
  int          cyc_no = 0;

  // Slave: mode 0 random waits (plus stray acks while idle), 1 fixed waits, 2 never acks.
  int          slv_mode = 1, slv_fix = 0, slv_max = 3, slv_wait = 0;
  bit          slv_act = 1'b0, slv_rdata_fix = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          p_req = 40;
  bit          rand_rst = 1'b0;

  // Advance one clock edge, apply the bus rules to the model, drive the slave.
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cyc_no++;
    if (rst) begin
      m_owner = NONE; m_last = OWN_IF; m_cnt = 0;
      m_we = 1'b0; m_sel = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
    end else if (m_owner == NONE) begin
      if (if_req && mem_req) m_owner = (m_last == OWN_IF) ? OWN_MEM : OWN_IF;
      else if (mem_req)      m_owner = OWN_MEM;
      else if (if_req)       m_owner = OWN_IF;
      if (m_owner == OWN_IF) begin
        m_we = 1'b0; m_sel = 4'hF; m_addr = if_addr; m_wdata = 32'h0;
      end else if (m_owner == OWN_MEM) begin
        m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wdata = mem_wdata;
      end
      m_cnt = 0;
    end else if (e_if_ack || e_mem_ack) begin
      m_last  = m_owner;
      m_owner = NONE;
    end else begin
      m_cnt++;
    end

    bus_ack   = 1'b0;
    bus_rdata = slv_rdata_fix ? slv_rdata : $urandom;
    if (!bus_req_o) begin
      slv_act = 1'b0;
      if (slv_mode == 0) bus_ack = ($urandom_range(7, 0) == 0);
    end else if (slv_mode != 2) begin
      if (!slv_act) begin
        slv_act  = 1'b1;
        slv_wait = (slv_mode == 1) ? slv_fix : int'($urandom_range(slv_max, 0));
      end
      if (slv_wait == 0) begin
        bus_ack = 1'b1;
        slv_act = 1'b0;
      end else begin
        slv_wait--;
      end
    end
  endtask

  // Let the inputs settle, then compare every output against the model.
  task automatic end_cycle();
    logic        tmo, done;
    logic [31:0] e_dat;
    #1;
    tmo       = ToEn && (m_owner != NONE) && (m_cnt == TO - 1);
    done      = !rst && (m_owner != NONE) && (bus_ack || tmo);
    e_if_ack  = done && (m_owner == OWN_IF);
    e_mem_ack = done && (m_owner == OWN_MEM);
    e_dat     = (done && bus_ack) ? bus_rdata : 32'h0;
    check_eq("bus_req",   32'(bus_req_o),   32'(m_owner != NONE));
    check_eq("bus_we",    32'(bus_we_o),    32'(m_we));
    check_eq("bus_sel",   32'(bus_sel_o),   32'(m_sel));
    check_eq("bus_addr",  bus_addr_o,       m_addr);
    check_eq("bus_wdata", bus_wdata_o,      m_wdata);
    check_eq("if_ack",    32'(if_ack_o),    32'(e_if_ack));
    check_eq("if_err",    32'(if_err_o),    32'(e_if_ack && !bus_ack));
    check_eq("if_data",   if_data_o,        e_if_ack ? e_dat : 32'h0);
    check_eq("mem_ack",   32'(mem_ack_o),   32'(e_mem_ack));
    check_eq("mem_err",   32'(mem_err_o),   32'(e_mem_ack && !bus_ack));
    check_eq("mem_rdata", mem_rdata_o,      e_mem_ack ? e_dat : 32'h0);
    check_eq("stallreq",  32'(stallreq_o),
             32'((if_req && !e_if_ack) || (mem_req && !e_mem_ack)));
    s_if_ack  = if_ack_o;
    s_mem_ack = mem_ack_o;
  endtask

  // Random requesters: hold until acked, then either chain a new request or drop.
  task automatic drive_reqs();
    rst = rand_rst && ($urandom_range(149, 0) == 0);
    if (if_req) begin
      if (s_if_ack) begin
        if ($urandom_range(1, 0) == 1) if_addr = $urandom;
        else                           if_req  = 1'b0;
      end
    end else if ($urandom_range(99, 0) < p_req) begin
      if_req = 1'b1; if_addr = $urandom;
    end
    if (mem_req) begin
      if (s_mem_ack) begin
        if ($urandom_range(1, 0) == 1) begin
          mem_addr = $urandom; mem_wdata = $urandom;
          mem_we = 1'($urandom); mem_sel = 4'($urandom);
        end else begin
          mem_req = 1'b0;
        end
      end
    end else if ($urandom_range(99, 0) < p_req) begin
      mem_req = 1'b1; mem_addr = $urandom; mem_wdata = $urandom;
      mem_we = 1'($urandom); mem_sel = 4'($urandom);
    end
  endtask

  int n_busy, n_ack, last_ack_cyc;

  initial begin
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    slv_mode = 1; slv_fix = 0; slv_rdata_fix = 1'b1; slv_rdata = 32'h3401_0020;

    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();
    check_eq("rst_bus_req",  32'(bus_req_o),  32'h0);
    check_eq("rst_bus_sel",  32'(bus_sel_o),  32'h0);
    check_eq("rst_bus_addr", bus_addr_o,      32'h0);
    check_eq("rst_stall",    32'(stallreq_o), 32'h0);

    // Fetch only, zero-wait slave.
    begin_cycle(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h100; end_cycle();
    begin_cycle(); end_cycle();
    check_eq("fetch_addr",  bus_addr_o,      32'h100);
    check_eq("fetch_we",    32'(bus_we_o),   32'h0);
    check_eq("fetch_sel",   32'(bus_sel_o),  32'hF);
    check_eq("fetch_ack",   32'(if_ack_o),   32'h1);
    check_eq("fetch_data",  if_data_o,       32'h3401_0020);
    check_eq("fetch_stall", 32'(stallreq_o), 32'h0);
    begin_cycle(); if_req = 1'b0; end_cycle();
    check_eq("fetch_pulse", 32'(if_ack_o), 32'h0);

    // Data write with three wait states.
    slv_fix = 3; slv_rdata_fix = 1'b0;
    begin_cycle();
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF;
    end_cycle();
    n_busy = 0; n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      begin_cycle(); if (s_mem_ack) mem_req = 1'b0; end_cycle();
      if (bus_req_o && bus_we_o && bus_sel_o == 4'b0011 && bus_addr_o == 32'h200 &&
          bus_wdata_o == 32'hDEAD_BEEF) n_busy++;
      if (mem_ack_o) n_ack++;
      if (bus_req_o && !mem_ack_o) check_eq("wr_stall", 32'(stallreq_o), 32'h1);
    end
    check_eq("wr_busy_cycles", n_busy, 4);
    check_eq("wr_acks",        n_ack,  1);

    // Sustained contention after reset: MEM, IF, MEM, IF, one ack per 2 cycles.
    slv_fix = 0;
    begin_cycle(); rst = 1'b1; end_cycle();
    begin_cycle();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h1000;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000;
    end_cycle();
    n_ack = 0; last_ack_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      begin_cycle();
      if (s_if_ack)  if_addr  = if_addr + 32'd4;
      if (s_mem_ack) mem_addr = mem_addr + 32'd4;
      end_cycle();
      if (if_ack_o || mem_ack_o) begin
        if (n_ack < 4)
          check_eq($sformatf("cont_owner%0d_is_mem", n_ack), 32'(mem_ack_o), 32'((n_ack % 2) == 0));
        if (n_ack > 0) check_eq("cont_gap", cyc_no - last_ack_cyc, 2);
        last_ack_cyc = cyc_no;
        n_ack++;
      end
    end
    check_eq("cont_acks", n_ack, 4);

    // Reset during a MEM transfer the slave never acks.
    slv_mode = 2;
    begin_cycle(); if_req = 1'b0; end_cycle();
    check_eq("rm_busy", 32'(bus_req_o), 32'h1);
    begin_cycle(); rst = 1'b1; end_cycle();
    check_eq("rm_noack_in_rst", 32'(mem_ack_o), 32'h0);
    begin_cycle(); rst = 1'b0; if_req = 1'b1; end_cycle();
    check_eq("rm_req_drop", 32'(bus_req_o), 32'h0);
    check_eq("rm_noack",    32'(mem_ack_o), 32'h0);
    begin_cycle(); end_cycle();
    check_eq("rm_regrant_req",  32'(bus_req_o), 32'h1);
    check_eq("rm_regrant_addr", bus_addr_o,     mem_addr);
    slv_mode = 1; slv_fix = 0;
    for (int i = 0; i < 6; i++) begin
      begin_cycle();
      if (s_if_ack)  if_req  = 1'b0;
      if (s_mem_ack) mem_req = 1'b0;
      end_cycle();
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Fetch the slave never acks: aborted in the 4th busy cycle.
    slv_mode = 2; slv_rdata_fix = 1'b1; slv_rdata = 32'hA5A5_0001;
    begin_cycle(); if_req = 1'b1; if_addr = 32'h300; end_cycle();
    for (int i = 1; i <= 4; i++) begin
      begin_cycle(); end_cycle();
      check_eq($sformatf("to_ack_c%0d", i), 32'(if_ack_o), 32'(i == 4));
      check_eq($sformatf("to_err_c%0d", i), 32'(if_err_o), 32'(i == 4));
    end
    check_eq("to_data", if_data_o, 32'h0);
    begin_cycle(); if_req = 1'b0; end_cycle();
    check_eq("to_idle", 32'(bus_req_o), 32'h0);

    // Ack in exactly the 4th busy cycle wins over the timeout.
    slv_mode = 1; slv_fix = 3;
    begin_cycle(); if_req = 1'b1; if_addr = 32'h304; end_cycle();
    for (int i = 1; i <= 4; i++) begin
      begin_cycle(); end_cycle();
      check_eq($sformatf("tb_ack_c%0d", i), 32'(if_ack_o), 32'(i == 4));
      check_eq($sformatf("tb_err_c%0d", i), 32'(if_err_o), 32'h0);
    end
    check_eq("tb_data", if_data_o, 32'hA5A5_0001);
    begin_cycle(); if_req = 1'b0; end_cycle();
`endif

    // Randomized traffic: heavy contention, then sparse requests.
    slv_mode = 0; slv_max = ToEn ? 5 : 3; slv_rdata_fix = 1'b0; rand_rst = 1'b1;
    p_req = 90;
    for (int i = 0; i < 1500; i++) begin begin_cycle(); drive_reqs(); end_cycle(); end
    p_req = 25;
    for (int i = 0; i < 1500; i++) begin begin_cycle(); drive_reqs(); end_cycle(); end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
